branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Pipeline controller for the decode-stage branch unit in the 5-stage core.
- Sequences boot, detects operand/flag hazards for CBZ and B.LT resolved in ID, and gates the raw taken signal into PC select.
- Drives PC/IF-ID write enables and ID/EX bubble insertion; keeps the single architectural delay-slot rule; exposes performance counters.

Parameters:
- BOOT_CYCLES, 2, cycles that fetch stays frozen after reset release (1..15).
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  4  decoded opcode in ID (shared opcode encoding).
- id_rt  in  5  CBZ source register in ID.
- br_taken_raw  in  1  raw taken decision from the decode-stage branch unit.
- ex_valid  in  1  EX stage valid.
- ex_opcode  in  4  opcode in EX.
- ex_rd  in  5  destination register in EX.
- mem_valid  in  1  MEM stage valid.
- mem_opcode  in  4  opcode in MEM.
- mem_rd  in  5  destination register in MEM.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- idex_bubble  out  1  load NOP into ID/EX this cycle.
- pc_sel  out  1  1 = next PC is branch target, 0 = PC+4.
- in_delay_slot  out  1  instruction now in ID is a taken branch's delay slot.
- halted  out  1  core stopped on INV.
- err_br_in_slot  out  1  sticky: branch seen in a delay slot.
- br_cnt  out  CNT_W  taken branches, saturating.
- stall_cnt  out  CNT_W  hazard-stall cycles, saturating.

Behaviour:
- Reset (async, reset_n=0): state=BOOT, boot counter=0, pc_we=0, ifid_we=0, idex_bubble=1, pc_sel=0, in_delay_slot=0, halted=0, err_br_in_slot=0, both counters=0. Reset mid-operation aborts any stall/halt immediately.
- FSM states:
  - BOOT: pc_we=ifid_we=0, idex_bubble=1. Leaves for RUN after exactly BOOT_CYCLES clock edges following reset release.
  - RUN: normal operation.
  - HALT: pc_we=ifid_we=0, idex_bubble=1, halted=1. Exit only by reset.
- Hazard (combinational, RUN only, requires id_valid). stall=1 when any of:
  - CBZ in ID, id_rt!=31, ex_valid, ex_opcode in {ADDI,ADDS,LSL,LSR,MUL,SUBS,LDUR}, and ex_rd==id_rt.
  - CBZ in ID, id_rt!=31, mem_valid, mem_opcode==LDUR, and mem_rd==id_rt.
  - BLT in ID, ex_valid, and ex_opcode in {ADDS,SUBS}.
- Resulting stall lengths: LDUR producer gives 2 stall cycles (EX, then MEM); ALU producer gives 1; flag producer gives 1.
- During stall: pc_we=0, ifid_we=0, idex_bubble=1, pc_sel=0, stall_cnt++.
- With no stall in RUN: pc_we=1, ifid_we=1, idex_bubble=0.
- pc_sel = br_taken_raw & id_valid & ~stall & ~in_delay_slot & opcode∈{B,BLT,CBZ}.
- Delay slot: in_delay_slot is registered; set on the edge where pc_sel=1, cleared on the next edge where ifid_we=1. No flush; the slot instruction always executes.
- Branch in ID while in_delay_slot=1: pc_sel forced 0, not counted, err_br_in_slot set (sticky until reset).
- br_cnt increments on every cycle with pc_sel=1.
- Counters saturate at all-ones and do not wrap.
- INV in ID with id_valid in RUN: transition to HALT on that edge. INV has priority over stall. The HALT outputs take effect from the next cycle.
- Simultaneous producer hazards: a single stall cycle per edge; conditions are re-evaluated every cycle.
- PC_INIT in ID is treated as a NOP.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode enum (PC_INIT=0, ADDI=1, ADDS=2, BLT=3, B=4, CBZ=5, LDUR=6, LSL=7, LSR=8, MUL=9, STUR=10, SUBS=11, INV=12);
  - ctrl_state_t {BOOT, RUN, HALT};
  - XZR=31 constant.
- One sub-module, branch_hazard_detect: purely combinational stall equation, reused by the forwarding unit bench.

Test Plan:
- Release reset_n with BOOT_CYCLES=2 -> pc_we=0 for 2 edges, pc_we=1 on the 3rd cycle; all counters 0.
- EX=LDUR rd=3, ID=CBZ rt=3 -> 2 stall cycles (idex_bubble=1, pc_we=0), stall_cnt=2. With rt=31: no stall.
- EX=SUBS, ID=BLT, br_taken_raw=1 -> 1 stall cycle, then pc_sel=1, br_cnt=1, in_delay_slot=1 next cycle.
- Taken B, then B in slot with br_taken_raw=1 -> pc_sel=0, err_br_in_slot=1, br_cnt stays 1.
- ID=INV -> halted=1 and pc_we=0 thereafter. Pulse reset_n low mid-HALT -> BOOT state, halted=0.
- Force stall for 2^CNT_W+3 cycles (CNT_W=4 override) -> stall_cnt holds at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: opcode encoding, controller states, and opcode class helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        PC_INIT = 4'd0,
        ADDI    = 4'd1,
        ADDS    = 4'd2,
        BLT     = 4'd3,
        B       = 4'd4,
        CBZ     = 4'd5,
        LDUR    = 4'd6,
        LSL     = 4'd7,
        LSR     = 4'd8,
        MUL     = 4'd9,
        STUR    = 4'd10,
        SUBS    = 4'd11,
        INV     = 4'd12
    } opcode_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] XZR = 5'd31;

    // Opcodes that write a general register (potential CBZ operand producers)
    function automatic logic writes_reg(input logic [3:0] op);
        case (opcode_t'(op))
            ADDI, ADDS, LSL, LSR, MUL, SUBS, LDUR: writes_reg = 1'b1;
            default:                               writes_reg = 1'b0;
        endcase
    endfunction

    // Opcodes that update the condition flags read by B.LT
    function automatic logic sets_flags(input logic [3:0] op);
        sets_flags = (opcode_t'(op) == ADDS) || (opcode_t'(op) == SUBS);
    endfunction

    // Opcodes handled by the decode-stage branch unit
    function automatic logic is_branch(input logic [3:0] op);
        is_branch = (opcode_t'(op) == B) || (opcode_t'(op) == BLT) || (opcode_t'(op) == CBZ);
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational stall equation for branches resolved in ID.
// A CBZ reads its register in ID, so any in-flight ALU result in EX or a load
// still in MEM must drain first; B.LT needs flags that are only final after EX.
module branch_hazard_detect
    import cpu_pkg::*;
(
    input  logic       id_valid,
    input  logic [3:0] id_opcode,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic [3:0] ex_opcode,
    input  logic [4:0] ex_rd,
    input  logic       mem_valid,
    input  logic [3:0] mem_opcode,
    input  logic [4:0] mem_rd,
    output logic       stall
);

    logic w_cbz;
    logic w_blt;
    logic w_ex_dep;
    logic w_mem_dep;
    logic w_flag_dep;

    // XZR reads are constant zero and can never depend on a producer
    always_comb begin
        w_cbz      = id_valid && (opcode_t'(id_opcode) == CBZ) && (id_rt != XZR);
        w_blt      = id_valid && (opcode_t'(id_opcode) == BLT);
        w_ex_dep   = w_cbz && ex_valid && writes_reg(ex_opcode) && (ex_rd == id_rt);
        w_mem_dep  = w_cbz && mem_valid && (opcode_t'(mem_opcode) == LDUR) && (mem_rd == id_rt);
        w_flag_dep = w_blt && ex_valid && sets_flags(ex_opcode);
        stall      = w_ex_dep || w_mem_dep || w_flag_dep;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch pipeline controller: boot sequencing, hazard stalls,
// taken-branch PC select with a single delay slot, halt on INV, perf counters.
module branch_ctrl
    import cpu_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [4:0]       id_rt,
    input  logic             br_taken_raw,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [4:0]       ex_rd,
    input  logic             mem_valid,
    input  logic [3:0]       mem_opcode,
    input  logic [4:0]       mem_rd,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             pc_sel,
    output logic             in_delay_slot,
    output logic             halted,
    output logic             err_br_in_slot,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_state_t      r_state;
    logic [3:0]       r_boot_cnt;
    logic             r_in_slot;
    logic             r_halted;
    logic             r_err;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_haz;
    logic w_run;
    logic w_stall;
    logic w_is_br;
    logic w_adv;
    logic w_pc_sel;

    branch_hazard_detect u_haz (
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rt      (id_rt),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_rd      (ex_rd),
        .mem_valid  (mem_valid),
        .mem_opcode (mem_opcode),
        .mem_rd     (mem_rd),
        .stall      (w_haz)
    );

    // Fetch advances only in RUN without a hazard; BOOT and HALT freeze it
    always_comb begin
        w_run    = (r_state == RUN);
        w_stall  = w_run && w_haz;
        w_is_br  = id_valid && is_branch(id_opcode);
        w_adv    = w_run && !w_stall;
        w_pc_sel = w_adv && br_taken_raw && w_is_br && !r_in_slot;
    end

    assign pc_we          = w_adv;
    assign ifid_we        = w_adv;
    assign idex_bubble    = !w_adv;
    assign pc_sel         = w_pc_sel;
    assign in_delay_slot  = r_in_slot;
    assign halted         = r_halted;
    assign err_br_in_slot = r_err;
    assign br_cnt         = r_br_cnt;
    assign stall_cnt      = r_stall_cnt;

    // Controller state, delay-slot tracking, sticky error and saturating counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= BOOT;
            r_boot_cnt  <= '0;
            r_in_slot   <= 1'b0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
            r_br_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (r_boot_cnt == 4'(BOOT_CYCLES - 1)) r_state <= RUN;
                    else                                   r_boot_cnt <= r_boot_cnt + 4'd1;
                end
                RUN: begin
                    if (id_valid && (opcode_t'(id_opcode) == INV)) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                default: r_state <= HALT;
            endcase

            // The slot instruction leaves ID on the next advancing edge
            if (w_pc_sel)   r_in_slot <= 1'b1;
            else if (w_adv) r_in_slot <= 1'b0;

            if (w_run && w_is_br && r_in_slot) r_err <= 1'b1;

            if (w_pc_sel && (r_br_cnt != '1))   r_br_cnt    <= r_br_cnt + 1'b1;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: vector table for the RUN-state behaviour
// plus hand sequences for boot, halt, async reset and counter saturation.
module tb_branch_ctrl;
    import cpu_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [4:0] id_rt;
    logic       br_taken_raw;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [4:0] ex_rd;
    logic       mem_valid;
    logic [3:0] mem_opcode;
    logic [4:0] mem_rd;

    logic        pc_we, ifid_we, idex_bubble, pc_sel, in_delay_slot, halted, err_br_in_slot;
    logic [31:0] br_cnt, stall_cnt;
    logic        pc_we4, ifid_we4, idex_bubble4, pc_sel4, in_delay_slot4, halted4, err4;
    logic [3:0]  br_cnt4, stall_cnt4;

    int total = 0;
    int bad   = 0;

    branch_ctrl #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rt(id_rt), .br_taken_raw(br_taken_raw), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .mem_valid(mem_valid),
        .mem_opcode(mem_opcode), .mem_rd(mem_rd), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_bubble(idex_bubble), .pc_sel(pc_sel), .in_delay_slot(in_delay_slot),
        .halted(halted), .err_br_in_slot(err_br_in_slot), .br_cnt(br_cnt),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation
    branch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rt(id_rt), .br_taken_raw(br_taken_raw), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .mem_valid(mem_valid),
        .mem_opcode(mem_opcode), .mem_rd(mem_rd), .pc_we(pc_we4), .ifid_we(ifid_we4),
        .idex_bubble(idex_bubble4), .pc_sel(pc_sel4), .in_delay_slot(in_delay_slot4),
        .halted(halted4), .err_br_in_slot(err4), .br_cnt(br_cnt4),
        .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic      idv; opcode_t idop; logic [4:0] rt; logic tk;
        logic      exv; opcode_t exop; logic [4:0] exrd;
        logic      mv;  opcode_t mop;  logic [4:0] mrd;
        logic      e_we; logic e_sel; logic e_slot; logic e_err;
        int        e_stc; int e_brc;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic idv, opcode_t idop, logic [4:0] rt, logic tk,
                                logic exv, opcode_t exop, logic [4:0] exrd,
                                logic mv, opcode_t mop, logic [4:0] mrd,
                                logic we, logic sel, logic slot, logic err, int stc, int brc);
        vec_t v;
        v.idv = idv; v.idop = idop; v.rt = rt; v.tk = tk;
        v.exv = exv; v.exop = exop; v.exrd = exrd;
        v.mv = mv; v.mop = mop; v.mrd = mrd;
        v.e_we = we; v.e_sel = sel; v.e_slot = slot; v.e_err = err;
        v.e_stc = stc; v.e_brc = brc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_opcode = ADDI; id_rt = 5'd0; br_taken_raw = 1'b0;
        ex_valid = 1'b0; ex_opcode = ADDI; ex_rd = 5'd0;
        mem_valid = 1'b0; mem_opcode = ADDI; mem_rd = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Boot: frozen for two edges after release, running on the third cycle
    task automatic boot_seq(input string tag);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk); chk({tag, "_boot_e0_pc_we"}, 32'(pc_we), 32'd0);
        next_cycle();
        @(negedge clk); chk({tag, "_boot_e1_pc_we"}, 32'(pc_we), 32'd0);
        chk({tag, "_boot_e1_bubble"}, 32'(idex_bubble), 32'd1);
        next_cycle();
        @(negedge clk); chk({tag, "_boot_e2_pc_we"}, 32'(pc_we), 32'd1);
        chk({tag, "_boot_e2_ifid_we"}, 32'(ifid_we), 32'd1);
        next_cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();

        //            idv op   rt tk  exv exop  exrd mv mop  mrd  we sel slot err stc brc
        vecs[0]  = mk(1, ADDI, 0, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, CBZ,  3, 1,  1, LDUR, 3,   0, ADDI, 0,   0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, CBZ,  3, 1,  0, ADDI, 0,   1, LDUR, 3,   0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(1, CBZ,  3, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 0, 2, 0);
        vecs[4]  = mk(1, CBZ, 31, 0,  1, LDUR, 31,  1, LDUR, 31,  1, 0, 0, 0, 2, 0);
        vecs[5]  = mk(1, CBZ,  5, 0,  1, ADDI, 5,   0, ADDI, 0,   0, 0, 0, 0, 2, 0);
        vecs[6]  = mk(1, CBZ,  5, 0,  1, STUR, 5,   0, ADDI, 0,   1, 0, 0, 0, 3, 0);
        vecs[7]  = mk(1, CBZ,  5, 0,  0, ADDI, 5,   0, ADDI, 0,   1, 0, 0, 0, 3, 0);
        vecs[8]  = mk(1, CBZ,  5, 0,  1, ADDI, 6,   0, ADDI, 0,   1, 0, 0, 0, 3, 0);
        vecs[9]  = mk(1, CBZ,  4, 0,  0, ADDI, 0,   1, ADDS, 4,   1, 0, 0, 0, 3, 0);
        vecs[10] = mk(1, BLT,  0, 1,  1, SUBS, 0,   0, ADDI, 0,   0, 0, 0, 0, 3, 0);
        vecs[11] = mk(1, BLT,  0, 1,  0, ADDI, 0,   0, ADDI, 0,   1, 1, 0, 0, 4, 0);
        vecs[12] = mk(1, ADDI, 0, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 1, 0, 4, 1);
        vecs[13] = mk(1, ADDI, 0, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 0, 4, 1);
        vecs[14] = mk(1, BLT,  0, 0,  1, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 0, 4, 1);
        vecs[15] = mk(1, B,    0, 1,  0, ADDI, 0,   0, ADDI, 0,   1, 1, 0, 0, 4, 1);
        vecs[16] = mk(1, B,    0, 1,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 1, 0, 4, 2);
        vecs[17] = mk(1, ADDI, 0, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 1, 4, 2);
        vecs[18] = mk(0, B,    0, 1,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 1, 4, 2);
        vecs[19] = mk(1, CBZ,  7, 1,  0, ADDI, 0,   0, ADDI, 0,   1, 1, 0, 1, 4, 2);
        vecs[20] = mk(1, CBZ,  7, 1,  1, MUL,  7,   0, ADDI, 0,   0, 0, 1, 1, 4, 3);
        vecs[21] = mk(1, CBZ,  7, 1,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 1, 1, 5, 3);
        vecs[22] = mk(1, ADDI, 0, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 1, 5, 3);
        vecs[23] = mk(1, CBZ,  9, 0,  1, LSL,  9,   1, LDUR, 9,   0, 0, 0, 1, 5, 3);
        vecs[24] = mk(1, CBZ,  9, 0,  0, ADDI, 0,   1, LDUR, 9,   0, 0, 0, 1, 6, 3);
        vecs[25] = mk(1, CBZ,  9, 0,  0, ADDI, 0,   0, ADDI, 0,   1, 0, 0, 1, 7, 3);

        // Reset state
        #3;
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_ifid_we", 32'(ifid_we), 32'd0);
        chk("rst_bubble", 32'(idex_bubble), 32'd1);
        chk("rst_pc_sel", 32'(pc_sel), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);

        boot_seq("a");

        // Vector table in RUN
        for (int i = 0; i < 26; i++) begin
            id_valid = vecs[i].idv; id_opcode = vecs[i].idop; id_rt = vecs[i].rt;
            br_taken_raw = vecs[i].tk;
            ex_valid = vecs[i].exv; ex_opcode = vecs[i].exop; ex_rd = vecs[i].exrd;
            mem_valid = vecs[i].mv; mem_opcode = vecs[i].mop; mem_rd = vecs[i].mrd;
            @(negedge clk);
            chk($sformatf("v%0d_pc_we", i), 32'(pc_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_ifid_we", i), 32'(ifid_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_bubble", i), 32'(idex_bubble), 32'(!vecs[i].e_we));
            chk($sformatf("v%0d_pc_sel", i), 32'(pc_sel), 32'(vecs[i].e_sel));
            chk($sformatf("v%0d_slot", i), 32'(in_delay_slot), 32'(vecs[i].e_slot));
            chk($sformatf("v%0d_err", i), 32'(err_br_in_slot), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_stall_cnt", i), stall_cnt, 32'(vecs[i].e_stc));
            chk($sformatf("v%0d_br_cnt", i), br_cnt, 32'(vecs[i].e_brc));
            next_cycle();
        end
        chk("end_stall_cnt", stall_cnt, 32'd7);
        chk("end_br_cnt", br_cnt, 32'd3);

        // INV: still advancing in its own cycle, halted from the next
        idle();
        id_valid = 1'b1; id_opcode = INV;
        @(negedge clk);
        chk("inv_cycle_pc_we", 32'(pc_we), 32'd1);
        chk("inv_cycle_halted", 32'(halted), 32'd0);
        next_cycle();
        id_opcode = BLT; br_taken_raw = 1'b1; ex_valid = 1'b1; ex_opcode = SUBS;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_halted", k), 32'(halted), 32'd1);
            chk($sformatf("halt%0d_pc_we", k), 32'(pc_we), 32'd0);
            chk($sformatf("halt%0d_bubble", k), 32'(idex_bubble), 32'd1);
            chk($sformatf("halt%0d_pc_sel", k), 32'(pc_sel), 32'd0);
            next_cycle();
        end
        chk("halt_stall_cnt", stall_cnt, 32'd7);
        chk("halt_br_cnt", br_cnt, 32'd3);

        // Asynchronous reset pulse mid-HALT, mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_pc_we", 32'(pc_we), 32'd0);
        chk("arst_bubble", 32'(idex_bubble), 32'd1);
        chk("arst_err", 32'(err_br_in_slot), 32'd0);
        chk("arst_stall_cnt", stall_cnt, 32'd0);
        chk("arst_br_cnt", br_cnt, 32'd0);
        idle();
        boot_seq("b");

        // Continuous flag hazard: narrow counter must saturate at 15
        id_valid = 1'b1; id_opcode = BLT; ex_valid = 1'b1; ex_opcode = SUBS;
        repeat (19) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_pc_we", 32'(pc_we4), 32'd0);
        chk("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
        chk("sat_stall_cnt32", stall_cnt, 32'd19);
        chk("sat_br_cnt4", 32'(br_cnt4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
